dual_port_byte_ram: RTL and testbench

- Byte-wide RAM with two ports.
- Port 1 is read/write and serves the CPU/system bus. Port 2 is read-only and serves the video scan-out, which fetches character codes combinationally.
- After reset, a built-in clear engine fills the whole array with FILL_VALUE and then raises ready.
- Used as the text RAM (80x30 = 2400 cells) of the character-mode video unit.

---
 rtl/dual_port_byte_ram.sv | 106 ++++++++++
 tb/tb_dual_port_byte_ram.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/dual_port_byte_ram.sv
// Byte-wide text RAM: read/write port 1 for the system bus, read-only port 2 for
// video scan-out, with a post-reset clear engine that fills the array before raising ready.
module dual_port_byte_ram #(
    parameter int           SIZE           = 2400,
    parameter int           AW             = $clog2(SIZE),
    parameter logic [7:0]   FILL_VALUE     = 8'h00,
    parameter bit           CLEAR_ON_RESET = 1'b1
) (
    input  logic            vga_clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   addr_1,
    input  logic [7:0]      wdata_1,
    input  logic            wenable_1,
    output logic [7:0]      rdata_1,
    input  logic [AW-1:0]   addr_2,
    output logic [7:0]      rdata_2,
    output logic            ready
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // One extra bit so the range check also works when SIZE is a power of two.
    localparam logic [AW:0]   SIZE_W     = (AW+1)'(SIZE);
    localparam logic [AW-1:0] LAST_ENTRY = AW'(SIZE - 1);

    logic [7:0]    mem [0:SIZE-1];

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] counter;
    logic [AW-1:0] counter_next;
    logic          ready_next;
    logic          clear_we;
    logic          user_we;
    logic          in_range_1;
    logic          in_range_2;

    assign in_range_1 = ({1'b0, addr_1} < SIZE_W);
    assign in_range_2 = ({1'b0, addr_2} < SIZE_W);

    always_ff @(posedge vga_clk) begin
        state   <= state_next;
        counter <= counter_next;
        ready   <= ready_next;
    end

    always_comb begin
        state_next   = state;
        counter_next = counter;
        ready_next   = ready;
        clear_we     = 1'b0;

        if (!rst_n) begin
            counter_next = '0;
            if (CLEAR_ON_RESET) begin
                state_next = CLEAR;
                ready_next = 1'b0;
            end else begin
                state_next = IDLE;
                ready_next = 1'b1;
            end
        end else begin
            case (state)
                CLEAR: begin
                    clear_we = 1'b1;
                    if (counter == LAST_ENTRY) begin
                        state_next   = IDLE;
                        ready_next   = 1'b1;
                        counter_next = '0;
                    end else begin
                        counter_next = counter + AW'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Bus writes are only honoured once the array is initialised; the clear engine has priority.
    assign user_we = rst_n && ready && wenable_1 && in_range_1;

    always_ff @(posedge vga_clk) begin
        if (clear_we) begin
            mem[counter] <= FILL_VALUE;
        end else if (user_we) begin
            mem[addr_1] <= wdata_1;
        end
    end

    always_comb begin
        rdata_1 = 8'h00;
        rdata_2 = 8'h00;
        if (in_range_1) begin
            rdata_1 = mem[addr_1];
        end
        if (in_range_2) begin
            rdata_2 = mem[addr_2];
        end
    end

endmodule

// File: tb/tb_dual_port_byte_ram.sv
// Directed-vector bench for dual_port_byte_ram: clear timing, writes, same-cycle
// read behaviour, out-of-range accesses, writes during clear and mid-clear reset.
module tb_dual_port_byte_ram;

    localparam int AW = 12;

    logic          vga_clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] addr_1;
    logic [7:0]    wdata_1;
    logic          wenable_1;
    logic [7:0]    rdata_1;
    logic [AW-1:0] addr_2;
    logic [7:0]    rdata_2;
    logic          ready;

    int vectorCount = 0;
    int failCount   = 0;
    int edges;

    dual_port_byte_ram dut (
        .vga_clk   (vga_clk),
        .rst_n     (rst_n),
        .addr_1    (addr_1),
        .wdata_1   (wdata_1),
        .wenable_1 (wenable_1),
        .rdata_1   (rdata_1),
        .addr_2    (addr_2),
        .rdata_2   (rdata_2),
        .ready     (ready)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Inputs change 1 time unit after the rising edge so outputs are sampled away from it.
    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [AW-1:0] a1, input logic [7:0] wd, input logic we, input logic [AW-1:0] a2);
        addr_1    = a1;
        wdata_1   = wd;
        wenable_1 = we;
        addr_2    = a2;
    endtask

    task automatic writeByte(input logic [AW-1:0] a, input logic [7:0] d);
        applyStimulus(a, d, 1'b1, a);
        step();
        wenable_1 = 1'b0;
    endtask

    task automatic checkBoth(input string tag, input logic [AW-1:0] a, input logic [7:0] expected);
        applyStimulus(a, 8'h00, 1'b0, a);
        #1;
        checkOutput({tag, "_p1"}, {24'h0, rdata_1}, {24'h0, expected});
        checkOutput({tag, "_p2"}, {24'h0, rdata_2}, {24'h0, expected});
    endtask

    task automatic waitReady(output int n);
        n = 0;
        while (ready !== 1'b1 && n < 3000) begin
            step();
            n++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus('0, 8'h00, 1'b0, '0);

        // Reset then full clear
        step();
        step();
        checkOutput("reset_ready", {31'h0, ready}, 32'd0);
        rst_n = 1'b1;
        waitReady(edges);
        checkOutput("clear_edges", edges, 32'd2400);
        checkBoth("clr_0", 12'd0, 8'h00);
        checkBoth("clr_1234", 12'd1234, 8'h00);
        checkBoth("clr_2399", 12'd2399, 8'h00);

        // Write and read back
        writeByte(12'd0, 8'h41);
        writeByte(12'd79, 8'h7E);
        writeByte(12'd2399, 8'hFF);
        checkBoth("wr_0", 12'd0, 8'h41);
        checkBoth("wr_79", 12'd79, 8'h7E);
        checkBoth("wr_2399", 12'd2399, 8'hFF);
        checkBoth("nb_1", 12'd1, 8'h00);
        checkBoth("nb_80", 12'd80, 8'h00);

        // Same-cycle visibility
        applyStimulus(12'd5, 8'hA5, 1'b1, 12'd5);
        #1;
        checkOutput("pre_edge_p1", {24'h0, rdata_1}, 32'h00);
        checkOutput("pre_edge_p2", {24'h0, rdata_2}, 32'h00);
        step();
        wenable_1 = 1'b0;
        checkOutput("post_edge_p1", {24'h0, rdata_1}, 32'hA5);
        checkOutput("post_edge_p2", {24'h0, rdata_2}, 32'hA5);
        addr_2 = 12'd0;
        #1;
        checkOutput("addr2_comb_p2", {24'h0, rdata_2}, 32'h41);
        checkOutput("addr2_comb_p1", {24'h0, rdata_1}, 32'hA5);

        // Out-of-range writes are ignored and read as zero
        writeByte(12'd2400, 8'h55);
        writeByte(12'd4095, 8'h55);
        checkBoth("oor_2400", 12'd2400, 8'h00);
        checkBoth("oor_4095", 12'd4095, 8'h00);
        checkBoth("oor_keep_0", 12'd0, 8'h41);
        checkBoth("oor_keep_2399", 12'd2399, 8'hFF);

        // Write attempted during clear is dropped; array is partially cleared meanwhile
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (10) step();
        checkOutput("mid_ready", {31'h0, ready}, 32'd0);
        applyStimulus(12'd5, 8'h00, 1'b0, 12'd2399);
        #1;
        checkOutput("partial_cleared_5", {24'h0, rdata_1}, 32'h00);
        checkOutput("partial_old_2399", {24'h0, rdata_2}, 32'hFF);
        addr_2 = 12'd79;
        #1;
        checkOutput("partial_old_79", {24'h0, rdata_2}, 32'h7E);
        applyStimulus(12'd2000, 8'h99, 1'b1, 12'd2000);
        step();
        wenable_1 = 1'b0;
        waitReady(edges);
        checkOutput("clear2_edges", edges + 11, 32'd2400);
        checkBoth("drop_2000", 12'd2000, 8'h00);
        checkBoth("clr2_79", 12'd79, 8'h00);

        // Mid-clear reset restarts from entry 0
        writeByte(12'd1500, 8'h12);
        writeByte(12'd2399, 8'h33);
        checkBoth("pre_mid_1500", 12'd1500, 8'h12);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (1000) step();
        rst_n = 1'b0;
        step();
        checkOutput("restart_ready", {31'h0, ready}, 32'd0);
        rst_n = 1'b1;
        waitReady(edges);
        checkOutput("restart_edges", edges, 32'd2400);
        checkBoth("restart_0", 12'd0, 8'h00);
        checkBoth("restart_1500", 12'd1500, 8'h00);
        checkBoth("restart_2399", 12'd2399, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
        $finish;
    end

endmodule
